// File: rtl/weight_mem_writer.sv
// Purpose : packs a serial stream of signed F_WIDTH weights into N_ROWS_ARRAY-lane
//           words and writes them to the weight memory write port.
// Latency : a word is written the cycle after its last lane is accepted.
//           done_o follows the final write by one cycle.
// Backpressure: w_ready_o is high only while packing. It drops for the write cycle,
//           and after the end address has been filled.
// Ports   : clk_i, rd_weight_rst (async, active-high)
//           start_i, base_addr_i, end_addr_i         - job control
//           w_valid_i, w_data_i, w_last_i, w_ready_o - weight stream
//           wr_mem2_ld_o, wr_addrs_mem2_o, mem2_data_o - weight memory write port
//           busy_o, done_o, trunc_o, words_o          - status
module weight_mem_writer #(
  parameter int N_ROWS_ARRAY    = 9,
  parameter int F_WIDTH         = 8,
  parameter int SIG_ADDRS_WIDTH = 10
) (
  input  logic                              clk_i,
  input  logic                              rd_weight_rst,
  input  logic                              start_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]        base_addr_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]        end_addr_i,
  input  logic                              w_valid_i,
  input  logic [F_WIDTH-1:0]                w_data_i,
  input  logic                              w_last_i,
  output logic                              w_ready_o,
  output logic                              wr_mem2_ld_o,
  output logic [SIG_ADDRS_WIDTH-1:0]        wr_addrs_mem2_o,
  output logic [N_ROWS_ARRAY*F_WIDTH-1:0]   mem2_data_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              trunc_o,
  output logic [SIG_ADDRS_WIDTH:0]          words_o
);

  localparam int DW = N_ROWS_ARRAY * F_WIDTH;
  localparam int LW = $clog2(N_ROWS_ARRAY + 1);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [SIG_ADDRS_WIDTH-1:0] addr_q, end_q;
  logic [LW-1:0]              lane_q;
  logic [DW-1:0]              buf_q, buf_d;
  logic                       last_q;
  logic                       beat;
  logic                       word_done;

  assign beat      = (state_q == S_PACK) && w_valid_i;
  assign word_done = beat && (w_last_i || (lane_q == LW'(N_ROWS_ARRAY - 1)));

  // Pack buffer with the current beat merged in; lanes not yet written stay zero
  // because the buffer is cleared at start and after every write.
  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < N_ROWS_ARRAY; k++) begin
      if (lane_q == LW'(k)) begin
        buf_d[k*F_WIDTH +: F_WIDTH] = w_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_PACK;
      S_PACK:  if (word_done) state_d = S_WRITE;
      S_WRITE: state_d = (last_q || (addr_q == end_q)) ? S_DONE : S_PACK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      w_ready_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      w_ready_o <= (state_d == S_PACK);
      busy_o    <= (state_d != S_IDLE);
      done_o    <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      addr_q          <= '0;
      end_q           <= '0;
      lane_q          <= '0;
      buf_q           <= '0;
      last_q          <= 1'b0;
      wr_mem2_ld_o    <= 1'b0;
      wr_addrs_mem2_o <= '0;
      mem2_data_o     <= '0;
      trunc_o         <= 1'b0;
      words_o         <= '0;
    end else begin
      wr_mem2_ld_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q  <= base_addr_i;
            end_q   <= end_addr_i;
            lane_q  <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            trunc_o <= 1'b0;
            words_o <= '0;
          end
        end
        S_PACK: begin
          if (beat) begin
            buf_q  <= buf_d;
            lane_q <= lane_q + LW'(1);
            if (w_last_i) last_q <= 1'b1;
            // The write port registers are loaded here so the strobe, address
            // and data all appear together in the WRITE cycle, then hold.
            if (word_done) begin
              wr_mem2_ld_o    <= 1'b1;
              wr_addrs_mem2_o <= addr_q;
              mem2_data_o     <= buf_d;
            end
          end
        end
        S_WRITE: begin
          words_o <= words_o + (SIG_ADDRS_WIDTH+1)'(1);
          if (!last_q) begin
            if (addr_q == end_q) begin
              trunc_o <= 1'b1;
            end else begin
              // Equality-terminated, so wrapping past the top is a legal range.
              addr_q <= addr_q + SIG_ADDRS_WIDTH'(1);
              lane_q <= '0;
              buf_q  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_mem_writer.sv
module tb_weight_mem_writer;

  localparam int N  = 9;
  localparam int FW = 8;
  localparam int AW = 10;
  localparam int DW = N * FW;

  logic          clk_i = 1'b0;
  logic          rd_weight_rst;
  logic          start_i;
  logic [AW-1:0] base_addr_i, end_addr_i;
  logic          w_valid_i;
  logic [FW-1:0] w_data_i;
  logic          w_last_i;
  logic          w_ready_o, wr_mem2_ld_o, busy_o, done_o, trunc_o;
  logic [AW-1:0] wr_addrs_mem2_o;
  logic [DW-1:0] mem2_data_o;
  logic [AW:0]   words_o;

  weight_mem_writer #(.N_ROWS_ARRAY(N), .F_WIDTH(FW), .SIG_ADDRS_WIDTH(AW)) dut (
    .clk_i(clk_i), .rd_weight_rst(rd_weight_rst), .start_i(start_i),
    .base_addr_i(base_addr_i), .end_addr_i(end_addr_i),
    .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_last_i(w_last_i), .w_ready_o(w_ready_o),
    .wr_mem2_ld_o(wr_mem2_ld_o), .wr_addrs_mem2_o(wr_addrs_mem2_o), .mem2_data_o(mem2_data_o),
    .busy_o(busy_o), .done_o(done_o), .trunc_o(trunc_o), .words_o(words_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Scoreboard of expected memory writes.
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t sb[$];

  int            done_cnt      = 0;
  logic          prev_ld       = 1'b0;
  logic          first_pending = 1'b0;
  logic [DW-1:0] first_data    = '0;

  always @(negedge clk_i) begin
    if (wr_mem2_ld_o) begin
      wr_t e;
      check("strobe_ready_low", w_ready_o, 1'b0);
      check("strobe_one_cycle", prev_ld, 1'b0);
      check("write_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_addr", wr_addrs_mem2_o, e.addr);
        check("wr_data", mem2_data_o, e.data);
      end
      if (first_pending) begin
        first_data    = mem2_data_o;
        first_pending = 1'b0;
      end
    end
    prev_ld = wr_mem2_ld_o;
    if (done_o) done_cnt++;
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] end_a;
    int            nbeats;
    bit            has_last;
    int            pat;       // 0 ramp 1..n, 1 fixed partial list, 2 random
    bit            gap;       // drop valid every third cycle
    int            sp;        // beat index at which a spurious start is pulsed, -1 none
    bit            pre_rst;   // abort a partial job with reset before this vector
    int            exp_words;
    bit            exp_trunc;
    bit            has_w0;
    logic [DW-1:0] w0;
  } vec_t;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_ready"}, w_ready_o, 1'b0);
    check({tag, "_ld"},      wr_mem2_ld_o, 1'b0);
    check({tag, "_addr"},    wr_addrs_mem2_o, '0);
    check({tag, "_data"},    mem2_data_o, '0);
    check({tag, "_busy"},    busy_o, 1'b0);
    check({tag, "_done"},    done_o, 1'b0);
    check({tag, "_trunc"},   trunc_o, 1'b0);
    check({tag, "_words"},   words_o, '0);
  endtask

  // Start a job, feed 4 beats, then reset asynchronously between clock edges.
  task automatic abort_with_reset();
    @(posedge clk_i); #1;
    base_addr_i = 10'd50; end_addr_i = 10'd60; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_valid_i = 1'b1; w_data_i = 8'hA0 + 8'(i); w_last_i = 1'b0;
      @(negedge clk_i);
      check("abort_beat_ready", w_ready_o, 1'b1);
      @(posedge clk_i); #1;
    end
    w_valid_i = 1'b0;
    #2 rd_weight_rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk_i);
    rd_weight_rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [FW-1:0] bt[$];
    logic [DW-1:0] word;
    logic [AW-1:0] a;
    int lane, exp_cons, idx, cyc;
    bit took, sp_done, is_last;

    for (int i = 0; i < v.nbeats; i++) begin
      case (v.pat)
        0:       bt.push_back(8'(i + 1));
        1:       begin
                   logic [31:0] lst;
                   lst = 32'h7F0180FF;
                   bt.push_back(lst[i*8 +: 8]);
                 end
        default: bt.push_back(8'($urandom_range(0, 255)));
      endcase
    end

    // Reference packing model.
    a = v.base; word = '0; lane = 0; exp_cons = 0;
    for (int i = 0; i < v.nbeats; i++) begin
      word[lane*FW +: FW] = bt[i];
      lane++;
      exp_cons++;
      is_last = v.has_last && (i == v.nbeats - 1);
      if (lane == N || is_last) begin
        sb.push_back('{addr: a, data: word});
        word = '0; lane = 0;
        if (is_last) break;
        if (a == v.end_a) break;
        a = a + 10'd1;
      end
    end

    done_cnt = 0; first_pending = 1'b1; sp_done = 1'b0;
    @(posedge clk_i); #1;
    base_addr_i = v.base; end_addr_i = v.end_a; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;

    idx = 0; cyc = 0;
    while (idx < v.nbeats && done_cnt == 0 && cyc < 2000) begin
      w_valid_i = !(v.gap && (cyc % 3 == 2));
      w_data_i  = bt[idx];
      w_last_i  = v.has_last && (idx == v.nbeats - 1);
      if (idx == v.sp && !sp_done) begin
        start_i = 1'b1; base_addr_i = 10'd300; end_addr_i = 10'd300; sp_done = 1'b1;
      end
      @(negedge clk_i);
      if (cyc == 0) check("ready_after_start", w_ready_o, 1'b1);
      took = w_valid_i && w_ready_o;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (took) idx++;
      cyc++;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    while (done_cnt == 0 && cyc < 2000) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    @(posedge clk_i); #1;

    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy_o, 1'b0);
    check("done_low_after", done_o, 1'b0);
    check("words", words_o, v.exp_words);
    check("trunc", trunc_o, v.exp_trunc);
    check("beats_consumed", idx, exp_cons);
    check("sb_drained", sb.size(), 0);
    if (v.has_w0) check("first_word", first_data, v.w0);
    sb.delete();
  endtask

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{10'd5,    10'd5,   9,  1'b1, 0, 1'b0, -1, 1'b0, 1, 1'b0, 1'b1, 72'h090807060504030201};
    vecs[1] = '{10'd0,    10'd7,   4,  1'b1, 1, 1'b0, -1, 1'b0, 1, 1'b0, 1'b1, 72'h00000000007F0180FF};
    vecs[2] = '{10'd100,  10'd110, 27, 1'b1, 2, 1'b1, 12, 1'b0, 3, 1'b0, 1'b0, '0};
    vecs[3] = '{10'd1023, 10'd0,   27, 1'b0, 2, 1'b0, -1, 1'b0, 2, 1'b1, 1'b0, '0};
    vecs[4] = '{10'd20,   10'd30,  13, 1'b1, 2, 1'b1, 2,  1'b0, 2, 1'b0, 1'b0, '0};
    vecs[5] = '{10'd50,   10'd60,  9,  1'b1, 0, 1'b0, -1, 1'b1, 1, 1'b0, 1'b1, 72'h090807060504030201};

    rd_weight_rst = 1'b1;
    start_i = 1'b0; base_addr_i = '0; end_addr_i = '0;
    w_valid_i = 1'b0; w_data_i = '0; w_last_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 check_reset_outputs("reset");
    @(negedge clk_i);
    rd_weight_rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre_rst) abort_with_reset();
      run_vec(vecs[i]);
    end

    repeat (5) @(posedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_mem_writer.md
# weight_mem_writer

Packs a serial stream of signed F_WIDTH filter weights into N_ROWS_ARRAY-lane words and writes them into the weight memory through its write port (mem2_data / wr_addrs_mem2 / wr_mem2_ld). It is the write-side counterpart of the weight read path: the controller reads these words back with rd_weight_ld and latches them into the per-row weight register. The block sits between the host/DMA weight stream and the weight memory, and shares that read path's reset.

## Interface
Parameters:
- N_ROWS_ARRAY, 9, number of weight lanes per memory word.
- F_WIDTH, 8, width of one weight in bits.
- SIG_ADDRS_WIDTH, 10, weight memory address width.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rd_weight_rst  in  1  reset; asynchronous, active-high; clock clk_i.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- base_addr_i  in  SIG_ADDRS_WIDTH  first word address; captured on start.
- end_addr_i  in  SIG_ADDRS_WIDTH  last permitted word address (inclusive); captured on start.
- w_valid_i  in  1  weight beat valid.
- w_data_i  in  F_WIDTH  signed weight.
- w_last_i  in  1  marks the final weight of the stream; qualified by w_valid_i.
- w_ready_o  out  1  weight beat accepted when w_valid_i && w_ready_o.
- wr_mem2_ld_o  out  1  weight memory write strobe.
- wr_addrs_mem2_o  out  SIG_ADDRS_WIDTH  write address.
- mem2_data_o  out  N_ROWS_ARRAY*F_WIDTH  write data; lane k is bits [(k+1)*F_WIDTH-1 : k*F_WIDTH].
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- trunc_o  out  1  sticky flag: the end address was filled before w_last_i was seen.
- words_o  out  SIG_ADDRS_WIDTH+1  number of words written since the last start.

## Operation
- State machine: IDLE -> PACK -> WRITE -> (PACK | DONE) -> IDLE.
- IDLE:
  - start_i captures base/end into internal registers, clears lane_cnt, words_o and trunc_o, and moves to PACK.
  - start_i received in any other state is ignored.
- PACK:
  - w_ready_o = 1.
  - Each accepted beat writes w_data_i into lane lane_cnt, then lane_cnt increments. Lane 0 receives the first weight.
  - Move to WRITE when the accepted beat fills lane N_ROWS_ARRAY-1, or when the accepted beat has w_last_i = 1.
  - On a w_last_i beat, lanes above the last written lane are zero-padded.
  - Record whether w_last_i was seen.
- WRITE (exactly one cycle):
  - wr_mem2_ld_o = 1, wr_addrs_mem2_o = current address, mem2_data_o = packed word.
  - words_o increments.
  - If w_last_i was seen -> DONE.
  - Else if current address == end address -> DONE with trunc_o = 1.
  - Else address increments -> PACK, with lane_cnt = 0 and the pack buffer cleared to 0.
- Address arithmetic is modulo 2^SIG_ADDRS_WIDTH: 1023 + 1 wraps to 0. Termination is by equality with the end address, so base > end is a legal wrapped range.
- DONE (one cycle): done_o = 1, then IDLE. trunc_o and words_o hold until the next accepted start.
- After truncation the block stops accepting beats: w_ready_o = 0. The remaining stream is the source's problem.
- w_valid_i with w_ready_o = 0 is not consumed. Data must be held by the source (valid/ready rules).
- Weights are stored unchanged (two's complement bit pattern). No sign extension or saturation.

## Timing
- Reset values: state IDLE, w_ready_o 0, wr_mem2_ld_o 0, wr_addrs_mem2_o 0, mem2_data_o 0, busy_o 0, done_o 0, trunc_o 0, words_o 0.
- Reset mid-operation clears everything immediately (asynchronous). No partial word is written.
- All outputs are registered. wr_addrs_mem2_o and mem2_data_o hold their last written values between strobes.
- Timeline:
  - start_i in cycle 0 -> w_ready_o = 1 in cycle 1.
  - Ninth beat accepted in cycle t -> wr_mem2_ld_o = 1 in cycle t+1, w_ready_o = 0 in cycle t+1.
  - Next beat can be accepted in cycle t+2.
- Peak throughput: one word per N_ROWS_ARRAY+1 cycles.
- done_o is asserted the cycle after the final WRITE cycle. busy_o drops the cycle after done_o.

## Test plan
- Single full word: base = end = 5, beats 1..9 with last on beat 9 -> one write at address 5, data 0x090807060504030201; done_o pulse; words_o = 1; trunc_o = 0.
- Partial word: base 0, end 7, beats 0xFF, 0x80, 0x01, 0x7F with last -> one write at address 0, data 0x0000000000_7F0180FF; words_o = 1.
- Multi-word stream with w_valid_i gaps every third cycle: 27 beats, base 100, end 110 -> writes at 100, 101, 102. The strobe is one cycle each, w_ready_o is low during each strobe, and no beat is lost or duplicated.
- Wrap and truncation: base 1023, end 0, 27 beats, no last -> writes at 1023 then 0; trunc_o = 1; w_ready_o stays 0 after the address-0 write; done_o pulses; words_o = 2.
- rd_weight_rst asserted mid-PACK, after 4 beats -> no write strobe; all outputs reach their reset values without waiting for a clock. A following start with 9 beats writes a clean word with no residue from the aborted lanes.
- start_i pulsed while busy -> ignored; address, words_o and the packed data are unchanged.
